uart_cmd_responder: RTL and testbench

//   Byte-level command engine on the far side of the UART FIFOs: pops received bytes from the
//   RX FIFO, assembles CR-terminated ASCII lines, executes register read/write commands on a

---
 rtl/uart_cmd_responder.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_uart_cmd_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_responder.sv
// -----------------------------------------------------------------------------
// uart_cmd_responder
//   Command engine behind the UART FIFOs. It pops bytes from the RX FIFO and
//   collects them into CR-terminated ASCII lines. It runs register read/write
//   commands on a simple register bus and pushes ASCII replies into the TX
//   FIFO.
//
//   Commands (letter is case-insensitive, hex digits may be either case):
//     Rhh    read register hh;   reply is two uppercase hex digits, CR, LF
//     Whhdd  write dd to hh;     reply is "K", CR, LF
//     V      version query;      reply is VERSION as two hex digits, CR, LF
//   A malformed line or an over-long line gets the reply "E", CR, LF.
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   rx_fifo_*            RX FIFO pop interface (data valid the cycle after pop)
//   tx_fifo_*            TX FIFO push interface (push only while not full)
//   reg_*                register bus: address, write data, strobes, read data
//   busy                 high from CR capture until the last reply byte is pushed
//   err_count            saturating count of "E" replies
// -----------------------------------------------------------------------------
module uart_cmd_responder #(
   parameter int         MAX_LINE = 8,
   parameter logic [7:0] VERSION  = 8'h01,
   parameter bit         ECHO     = 1'b0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx_fifo_empty,
   input  logic [7:0] rx_fifo_data,
   output logic       rx_fifo_read_en,
   input  logic       tx_fifo_full,
   output logic [7:0] tx_fifo_data,
   output logic       tx_fifo_write_en,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   output logic       reg_re,
   input  logic [7:0] reg_rdata,
   output logic       busy,
   output logic [7:0] err_count
);

   localparam int LW = $clog2(MAX_LINE + 1);
   // Only the first five characters can form a valid command.
   // Later characters only count toward the line length.
   localparam int KEEP = 5;
   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_CR = 8'h0D;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_POP    = 3'd1,
      S_CAPT   = 3'd2,
      S_EXEC   = 3'd3,
      S_RDWAIT = 3'd4,
      S_RESP   = 3'd5
   } state_e;

   // Decodes an ASCII hex digit into {valid, nibble}.
   function automatic logic [4:0] hex_dec(input logic [7:0] c);
      logic [4:0] r;
      if (c >= 8'h30 && c <= 8'h39) begin
         r = {1'b1, c[3:0]};
      end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
         r = {1'b1, c[3:0] + 4'd9};
      end else begin
         r = 5'd0;
      end
      return r;
   endfunction

   // Encodes a nibble as an uppercase ASCII hex digit.
   function automatic logic [7:0] to_hex(input logic [3:0] n);
      logic [7:0] r;
      if (n < 4'd10) begin
         r = 8'h30 + {4'd0, n};
      end else begin
         r = 8'h37 + {4'd0, n};
      end
      return r;
   endfunction

   // Folds a lowercase letter to uppercase.
   function automatic logic [7:0] upcase(input logic [7:0] c);
      logic [7:0] r;
      if (c >= 8'h61 && c <= 8'h7A) begin
         r = c - 8'h20;
      end else begin
         r = c;
      end
      return r;
   endfunction

   state_e      state_q, state_d, capt_next_s;
   logic [LW-1:0] len_q, len_d;
   logic        ovf_q, ovf_d;
   logic [7:0]  line_q [KEEP];
   logic [7:0]  line_d [KEEP];
   logic [7:0]  tx_buf_q [4];
   logic [7:0]  tx_buf_d [4];
   logic [1:0]  tx_idx_q, tx_idx_d;
   logic [1:0]  tx_last_q, tx_last_d;
   logic        ret_exec_q, ret_exec_d;   // reply buffer holds an echoed CR; run EXEC afterwards
   logic        rd_pend_q, rd_pend_d;     // reg_rdata must be captured on the next RESP cycle
   logic        rd_en_q, rd_en_d;
   logic        tx_we_q, tx_we_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic [7:0]  addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        we_q, we_d;
   logic        re_q, re_d;
   logic        busy_q, busy_d;
   logic [7:0]  err_q, err_d;

   logic [7:0]  cmd_s;
   logic [4:0]  h1_s, h2_s, h3_s, h4_s;

   assign cmd_s = upcase(line_q[0]);
   assign h1_s  = hex_dec(line_q[1]);
   assign h2_s  = hex_dec(line_q[2]);
   assign h3_s  = hex_dec(line_q[3]);
   assign h4_s  = hex_dec(line_q[4]);

   assign rx_fifo_read_en  = rd_en_q;
   assign tx_fifo_data     = tx_data_q;
   assign tx_fifo_write_en = tx_we_q;
   assign reg_addr         = addr_q;
   assign reg_wdata        = wdata_q;
   assign reg_we           = we_q;
   assign reg_re           = re_q;
   assign busy             = busy_q;
   assign err_count        = err_q;

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         ovf_q      <= 1'b0;
         line_q     <= '{default: 8'h00};
         tx_buf_q   <= '{default: 8'h00};
         tx_idx_q   <= 2'd0;
         tx_last_q  <= 2'd0;
         ret_exec_q <= 1'b0;
         rd_pend_q  <= 1'b0;
         rd_en_q    <= 1'b0;
         tx_we_q    <= 1'b0;
         tx_data_q  <= 8'h00;
         addr_q     <= 8'h00;
         wdata_q    <= 8'h00;
         we_q       <= 1'b0;
         re_q       <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 8'h00;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         ovf_q      <= ovf_d;
         line_q     <= line_d;
         tx_buf_q   <= tx_buf_d;
         tx_idx_q   <= tx_idx_d;
         tx_last_q  <= tx_last_d;
         ret_exec_q <= ret_exec_d;
         rd_pend_q  <= rd_pend_d;
         rd_en_q    <= rd_en_d;
         tx_we_q    <= tx_we_d;
         tx_data_q  <= tx_data_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         re_q       <= re_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
      end
   end

   // Next-state logic: line assembly, command decode and reply sequencing.
   always_comb begin
      state_d     = state_q;
      capt_next_s = S_IDLE;
      len_d       = len_q;
      ovf_d       = ovf_q;
      line_d      = line_q;
      tx_buf_d    = tx_buf_q;
      tx_idx_d    = tx_idx_q;
      tx_last_d   = tx_last_q;
      ret_exec_d  = ret_exec_q;
      rd_pend_d   = rd_pend_q;
      rd_en_d     = 1'b0;
      tx_we_d     = 1'b0;
      tx_data_d   = tx_data_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      we_d        = 1'b0;
      re_d        = 1'b0;
      busy_d      = busy_q;
      err_d       = err_q;

      case (state_q)
         S_IDLE: begin
            if (!rx_fifo_empty) begin
               rd_en_d = 1'b1;
               state_d = S_POP;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_POP: begin
            state_d = S_CAPT;
         end

         S_CAPT: begin
            if (rx_fifo_data == CH_LF) begin
               capt_next_s = S_IDLE;
            end else if (rx_fifo_data == CH_CR) begin
               if (len_q == '0) begin
                  capt_next_s = S_IDLE;
               end else begin
                  capt_next_s = S_EXEC;
                  busy_d      = 1'b1;
               end
            end else if (len_q < LW'(MAX_LINE)) begin
               for (int i = 0; i < KEEP; i++) begin
                  line_d[i] = (len_q == LW'(i)) ? rx_fifo_data : line_q[i];
               end
               len_d       = len_q + LW'(1);
               capt_next_s = S_IDLE;
            end else begin
               ovf_d       = 1'b1;
               capt_next_s = S_IDLE;
            end
            // With ECHO, the byte goes out through the reply path first.
            // The state saved in capt_next_s resumes after the echo.
            if (ECHO && (rx_fifo_data != CH_LF)) begin
               tx_buf_d[0] = rx_fifo_data;
               tx_idx_d    = 2'd0;
               tx_last_d   = 2'd0;
               ret_exec_d  = (capt_next_s == S_EXEC);
               state_d     = S_RESP;
            end else begin
               state_d = capt_next_s;
            end
         end

         S_EXEC: begin
            len_d    = '0;
            ovf_d    = 1'b0;
            tx_idx_d = 2'd0;
            if (!ovf_q && cmd_s == 8'h52 && len_q == LW'(3) && h1_s[4] && h2_s[4]) begin
               addr_d  = {h1_s[3:0], h2_s[3:0]};
               re_d    = 1'b1;
               state_d = S_RDWAIT;
            end else if (!ovf_q && cmd_s == 8'h57 && len_q == LW'(5) &&
                         h1_s[4] && h2_s[4] && h3_s[4] && h4_s[4]) begin
               addr_d      = {h1_s[3:0], h2_s[3:0]};
               wdata_d     = {h3_s[3:0], h4_s[3:0]};
               we_d        = 1'b1;
               tx_buf_d[0] = 8'h4B;
               tx_buf_d[1] = CH_CR;
               tx_buf_d[2] = CH_LF;
               tx_last_d   = 2'd2;
               state_d     = S_RESP;
            end else if (!ovf_q && cmd_s == 8'h56 && len_q == LW'(1)) begin
               tx_buf_d[0] = to_hex(VERSION[7:4]);
               tx_buf_d[1] = to_hex(VERSION[3:0]);
               tx_buf_d[2] = CH_CR;
               tx_buf_d[3] = CH_LF;
               tx_last_d   = 2'd3;
               state_d     = S_RESP;
            end else begin
               tx_buf_d[0] = 8'h45;
               tx_buf_d[1] = CH_CR;
               tx_buf_d[2] = CH_LF;
               tx_last_d   = 2'd2;
               err_d       = (err_q != 8'hFF) ? err_q + 8'd1 : err_q;
               state_d     = S_RESP;
            end
         end

         S_RDWAIT: begin
            rd_pend_d = 1'b1;
            state_d   = S_RESP;
         end

         S_RESP: begin
            if (rd_pend_q) begin
               tx_buf_d[0] = to_hex(reg_rdata[7:4]);
               tx_buf_d[1] = to_hex(reg_rdata[3:0]);
               tx_buf_d[2] = CH_CR;
               tx_buf_d[3] = CH_LF;
               tx_idx_d    = 2'd0;
               tx_last_d   = 2'd3;
               rd_pend_d   = 1'b0;
            end else if (!tx_we_q && !tx_fifo_full) begin
               // Push at most every other cycle so that the full flag
               // reflects our own previous push before we decide again.
               tx_we_d   = 1'b1;
               tx_data_d = tx_buf_q[tx_idx_q];
               if (tx_idx_q == tx_last_q) begin
                  ret_exec_d = 1'b0;
                  if (ret_exec_q) begin
                     state_d = S_EXEC;
                  end else begin
                     busy_d  = 1'b0;
                     state_d = S_IDLE;
                  end
               end else begin
                  tx_idx_d = tx_idx_q + 2'd1;
               end
            end else begin
               state_d = S_RESP;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_cmd_responder.sv
module tb_uart_cmd_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic       tx_full;

   // Instance 0: ECHO = 0
   logic       rx_empty0 = 1'b1;
   logic [7:0] rx_data0 = 8'h00;
   logic       rd_en0, tx_we0, we0, re0, busy0;
   logic [7:0] tx_data0, addr0, wdata0, rdata0, err0;

   // Instance 1: ECHO = 1
   logic       rx_empty1 = 1'b1;
   logic [7:0] rx_data1 = 8'h00;
   logic       rd_en1, tx_we1, we1, re1, busy1;
   logic [7:0] tx_data1, addr1, wdata1, rdata1, err1;

   logic [7:0]  rxq0[$];
   logic [7:0]  rxq1[$];
   logic [7:0]  expq0[$];
   logic [7:0]  expq1[$];
   logic [17:0] evq0[$];   // {re, we, addr, wdata-or-0}

   int n_cmp;
   int n_mis;

   // Register file model: 0x3A reads 0x5C, every other address reads addr^0xA5
   assign rdata0 = (addr0 == 8'h3A) ? 8'h5C : (addr0 ^ 8'hA5);
   assign rdata1 = 8'h00;

   uart_cmd_responder #(.MAX_LINE(8), .VERSION(8'h01), .ECHO(1'b0)) dut (
      .clk(clk), .reset_n(reset_n),
      .rx_fifo_empty(rx_empty0), .rx_fifo_data(rx_data0), .rx_fifo_read_en(rd_en0),
      .tx_fifo_full(tx_full), .tx_fifo_data(tx_data0), .tx_fifo_write_en(tx_we0),
      .reg_addr(addr0), .reg_wdata(wdata0), .reg_we(we0), .reg_re(re0),
      .reg_rdata(rdata0), .busy(busy0), .err_count(err0)
   );

   uart_cmd_responder #(.MAX_LINE(8), .VERSION(8'h01), .ECHO(1'b1)) dut_echo (
      .clk(clk), .reset_n(reset_n),
      .rx_fifo_empty(rx_empty1), .rx_fifo_data(rx_data1), .rx_fifo_read_en(rd_en1),
      .tx_fifo_full(tx_full), .tx_fifo_data(tx_data1), .tx_fifo_write_en(tx_we1),
      .reg_addr(addr1), .reg_wdata(wdata1), .reg_we(we1), .reg_re(re1),
      .reg_rdata(rdata1), .busy(busy1), .err_count(err1)
   );

   // RX FIFO models: data registered on the pop edge, empty follows queue
   always @(posedge clk) begin
      if (rd_en0 && rxq0.size() > 0) rx_data0 <= rxq0.pop_front();
      rx_empty0 <= (rxq0.size() == 0);
      if (rd_en1 && rxq1.size() > 0) rx_data1 <= rxq1.pop_front();
      rx_empty1 <= (rxq1.size() == 0);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic unexpected(input string nm, input logic [63:0] act);
      n_cmp++;
      n_mis++;
      $display("FAIL %s: got %0h expected nothing", nm, act);
   endtask

   task automatic send0(input string s);
      for (int i = 0; i < s.len(); i++) rxq0.push_back(s[i]);
      rxq0.push_back(8'h0D);
   endtask

   task automatic exp0(input string s);
      for (int i = 0; i < s.len(); i++) expq0.push_back(s[i]);
      expq0.push_back(8'h0D);
      expq0.push_back(8'h0A);
   endtask

   task automatic wait_done(input string nm);
      int k;
      k = 0;
      while (k < 500 && !(expq0.size() == 0 && expq1.size() == 0 && evq0.size() == 0 &&
                          rxq0.size() == 0 && rxq1.size() == 0 && !busy0 && !busy1)) begin
         @(negedge clk);
         k++;
      end
      if (k >= 500) begin
         n_cmp++;
         n_mis++;
         $display("FAIL %s: timeout, %0d TX bytes still expected", nm, expq0.size() + expq1.size());
      end
      repeat (12) @(negedge clk);
   endtask

   task automatic wait_busy(input string nm);
      int k;
      k = 0;
      while (k < 100 && !busy0) begin
         @(negedge clk);
         k++;
      end
      if (k >= 100) begin
         n_cmp++;
         n_mis++;
         $display("FAIL %s: timeout waiting for busy, got %0b expected 1", nm, busy0);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      tx_full = 1'b0;
      n_cmp   = 0;
      n_mis   = 0;

      // Monitor: compares every TX push and bus strobe against the scoreboard
      fork
         forever begin
            @(negedge clk);
            if (tx_we0) begin
               chk("tx0_full_on_write", {63'd0, tx_full}, 64'd0);
               if (expq0.size() == 0) unexpected("tx0_extra_byte", tx_data0);
               else chk("tx0_byte", tx_data0, expq0.pop_front());
            end
            if (tx_we1) begin
               chk("tx1_full_on_write", {63'd0, tx_full}, 64'd0);
               if (expq1.size() == 0) unexpected("tx1_extra_byte", tx_data1);
               else chk("tx1_byte", tx_data1, expq1.pop_front());
            end
            if (re0 || we0) begin
               if (evq0.size() == 0) unexpected("bus0_extra_strobe", {re0, we0, addr0, wdata0});
               else chk("bus0_strobe", {re0, we0, addr0, we0 ? wdata0 : 8'h00}, evq0.pop_front());
            end
            if (re1 || we1) unexpected("bus1_strobe", {re1, we1, addr1, wdata1});
         end
      join_none

      repeat (3) @(negedge clk);
      chk("reset_outputs", {rd_en0, tx_we0, tx_data0, addr0, wdata0, we0, re0, busy0, err0}, 64'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Register read
      evq0.push_back({1'b1, 1'b0, 8'h3A, 8'h00});
      exp0("5C");
      send0("R3A");
      wait_done("read_3a");

      // Lowercase write, then a lone LF that must produce nothing
      evq0.push_back({1'b0, 1'b1, 8'h10, 8'hFF});
      exp0("K");
      send0("w10ff");
      rxq0.push_back(8'h0A);
      wait_done("write_10");
      chk("write_addr_wdata", {addr0, wdata0}, 64'h10FF);
      chk("err_after_good", err0, 64'd0);

      // Error cases: unknown letter, bad hex, wrong length, overflow
      exp0("E"); send0("Q");         wait_done("err_q");
      exp0("E"); send0("R3G");       wait_done("err_r3g");
      exp0("E"); send0("W12");       wait_done("err_w12");
      exp0("E"); send0("R3A3A3A3A"); wait_done("err_overflow");
      chk("err_count_4", err0, 64'd4);
      chk("addr_held", {addr0, wdata0}, 64'h10FF);

      // TX FIFO full for 20 cycles during V reply
      tx_full = 1'b1;
      exp0("01");
      send0("V");
      wait_busy("v_full");
      repeat (20) @(negedge clk);
      chk("busy_while_stalled", {63'd0, busy0}, 64'd1);
      chk("bytes_pending_while_full", expq0.size(), 64'd4);
      tx_full = 1'b0;
      wait_done("v_after_full");

      // Reset in the middle of a stalled reply
      tx_full = 1'b1;
      exp0("01");
      send0("V");
      wait_busy("v_reset");
      repeat (5) @(negedge clk);
      reset_n = 1'b0;
      expq0.delete();
      @(negedge clk);
      chk("midreset_outputs", {rd_en0, tx_we0, tx_data0, addr0, wdata0, we0, re0, busy0, err0}, 64'd0);
      tx_full = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      evq0.push_back({1'b1, 1'b0, 8'h00, 8'h00});
      exp0("A5");
      send0("R00");
      wait_done("read_after_reset");
      chk("err_after_reset", err0, 64'd0);

      // Echo instance: V<CR> -> 'V', CR, '0', '1', CR, LF
      expq1.push_back(8'h56);
      expq1.push_back(8'h0D);
      expq1.push_back(8'h30);
      expq1.push_back(8'h31);
      expq1.push_back(8'h0D);
      expq1.push_back(8'h0A);
      rxq1.push_back(8'h56);
      rxq1.push_back(8'h0D);
      wait_done("echo_v");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
